// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel clock divider:
//   - default divisor width and reset divisor
//   - chan_out_t : registered outputs of one divider channel
//   - ceil_half  : number of high cycles in a period of length d
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DIV_W_DEFAULT       = 10;
    localparam int DEFAULT_DIV_DEFAULT = 500;
    localparam int N_CH_MAX            = 8;

    // Registered per-channel outputs, gathered so the top level can fan them
    // back out into the per-signal output vectors.
    typedef struct packed {
        logic clock_out;
        logic tick;
        logic pending;
    } chan_out_t;

    // High phase length for a period of d cycles. Written as d/2 + lsb so it
    // cannot overflow when d is the largest value of its width.
    function automatic int unsigned ceil_half(input int unsigned d);
        return (d >> 1) + (d & 32'd1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: period counter, active/pending divisor and registered
// clock/tick outputs. A newly loaded divisor is held as pending and only takes
// over at a period boundary, so a period in progress is never cut short.
//
// Ports:
//   clock_in    in   system clock
//   reset       in   asynchronous active-high reset
//   enable      in   run enable; low parks the counter at 0 with outputs low
//   load        in   capture load_value as the pending divisor
//   load_value  in   DIV_W  divisor to capture
//   restart     in   zero the counter and apply any pending divisor
//   status      out  chan_out_t {clock_out, tick, pending}, all registered
// -----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [DIV_W-1:0] load_value,
    input  logic             restart,
    output chan_out_t        status
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pending_div;
    logic             clock_q;
    logic             tick_q;
    logic             pending_q;

    logic [DIV_W-1:0] last_cnt;
    logic [DIV_W-1:0] half_div;
    logic             div_multi;
    logic             at_last;
    logic             apply_div;

    // Period decode. last_cnt is only formed when the divisor is at least 2,
    // so 0 and 1 never wrap around to an all-ones compare value.
    always_comb begin
        div_multi = (active_div > DIV_W'(1));
        last_cnt  = '0;
        if (div_multi) begin
            last_cnt = active_div - DIV_W'(1);
        end
        at_last   = div_multi && (cnt == last_cnt);
        half_div  = DIV_W'(ceil_half(32'(active_div)));
        // Divisors 0/1 and a disabled channel have no period in flight, so a
        // pending value may be taken over straight away.
        apply_div = pending_q && (at_last || !enable || !div_multi || restart);
    end

    // Counter and output registers, driven from the pre-update count.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            clock_q <= 1'b0;
            tick_q  <= 1'b0;
        end else if (!enable || (active_div == '0)) begin
            cnt     <= '0;
            clock_q <= 1'b0;
            tick_q  <= 1'b0;
        end else if (!div_multi) begin
            cnt     <= '0;
            clock_q <= 1'b1;
            tick_q  <= 1'b1;
        end else begin
            clock_q <= (cnt < half_div);
            tick_q  <= at_last;
            if (restart || at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

    // Divisor registers. A load in the same cycle as an application lands
    // in pending_div after the older pending value has been taken over, so it
    // waits for the next boundary.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            active_div  <= DIV_W'(DEFAULT_DIV);
            pending_div <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (apply_div) begin
                active_div <= pending_div;
                pending_q  <= 1'b0;
            end
            if (load) begin
                pending_div <= load_value;
                pending_q   <= 1'b1;
            end
        end
    end

    assign status.clock_out = clock_q;
    assign status.tick      = tick_q;
    assign status.pending   = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// Multi-channel runtime-programmable clock divider. Each channel produces a
// near-50% divided clock and a one-cycle tick at the last count of its period.
// Divisors are reloaded glitch-free at period boundaries; restart phase-aligns
// all channels at once.
//
// Ports:
//   clock_in   in   system clock (100 MHz)
//   reset      in   asynchronous active-high reset
//   enable     in   N_CH   per-channel run enable
//   div_load   in   strobe: write div_value to channel div_sel
//   div_sel    in   CH_W   target channel (values >= N_CH are ignored)
//   div_value  in   DIV_W  new divisor
//   restart    in   strobe: zero every channel counter together
//   clock_out  out  N_CH   divided clocks, registered
//   tick       out  N_CH   end-of-period pulses, registered
//   pending    out  N_CH   a loaded divisor is waiting to take effect
// -----------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEFAULT,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [N_CH-1:0]  enable,
    input  logic             div_load,
    input  logic [CH_W-1:0]  div_sel,
    input  logic [DIV_W-1:0] div_value,
    input  logic             restart,
    output logic [N_CH-1:0]  clock_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic      ch_load;
        chan_out_t ch_status;

        // Only one channel can match; a select beyond the last channel
        // matches none, so the load is dropped.
        assign ch_load = div_load && (div_sel == CH_W'(i));

        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clock_in   (clock_in),
            .reset      (reset),
            .enable     (enable[i]),
            .load       (ch_load),
            .load_value (div_value),
            .restart    (restart),
            .status     (ch_status)
        );

        assign clock_out[i] = ch_status.clock_out;
        assign tick[i]      = ch_status.tick;
        assign pending[i]   = ch_status.pending;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel, runtime-programmable clock divider. Successor to the fixed single-divisor refresh-clock generator.
- Each channel derives a near-50% duty divided clock and a one-cycle tick strobe from the 100 MHz board clock.
- Divisors are reloadable glitch-free at period boundaries. All channels can be phase-aligned by one restart strobe.
- Feeds sensor, display-refresh and debounce timing in the top level.

Parameters:
- N_CH, 2, number of independent divider channels (1..8)
- DIV_W, 10, divisor and counter width in bits
- DEFAULT_DIV, 500, divisor loaded into every channel at reset (must be < 2^DIV_W)
- CH_W (localparam), max(1, clog2(N_CH)), channel-select width

Ports:
- clock_in  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- enable  input  N_CH  per-channel run enable
- div_load  input  1  single-cycle strobe: write div_value to channel div_sel
- div_sel  input  CH_W  target channel for div_load
- div_value  input  DIV_W  new divisor
- restart  input  1  single-cycle strobe: zero all channel counters together
- clock_out  output  N_CH  divided clocks, registered
- tick  output  N_CH  one-cycle pulse at the last count of each period, registered
- pending  output  N_CH  high while a loaded divisor waits to take effect

Behaviour:
- Reset (async assert, sync release): cnt=0, active_div=DEFAULT_DIV, pending_div=0, pending=0, clock_out=0, tick=0.
- Per channel, enabled, active_div=D>=2:
  - cnt counts 0..D-1, then wraps to 0.
  - Outputs are registered from the pre-update count: clock_out(t+1) = (cnt(t) < ceil(D/2)); tick(t+1) = (cnt(t) == D-1).
  - D=4: clock_out 1,1,0,0. D=5: high 3 cycles, low 2. tick high once per D cycles, coincident with the last low cycle.
- D=1: clock_out held 1; tick high every cycle.
- D=0: channel parked; cnt held 0, clock_out=0, tick=0.
- enable[i]=0: cnt forced 0, clock_out=0 and tick=0 from the next cycle. On re-enable, counting starts at cnt=0, so the first output cycle is high.
- div_load:
  - div_value is captured into pending_div of channel div_sel; pending=1 the next cycle.
  - div_sel >= N_CH is ignored.
  - Repeated loads before application: the last one wins.
- Application of pending_div happens when any of these is true:
  - the cycle cnt==active_div-1 (wrap)
  - the channel is disabled
  - active_div is 0 or 1
  - restart
- On application: active_div <= pending_div, pending <= 0, and the next period uses the new value. The period in progress is never truncated, so there are no runt pulses.
- Load in the same cycle as a wrap: the new value is captured and applied at the following wrap, not the current one.
- restart:
  - All enabled channels set cnt=0 in the same cycle and apply any pending divisor.
  - restart takes priority over wrap and load-application.
  - A div_load in the same cycle is still captured, as pending.
- Reset mid-period: outputs drop immediately (async); DEFAULT_DIV is restored and any pending value is discarded.
- Counter arithmetic is DIV_W bits. The compare uses D-1 computed only when D>=2, so there is no underflow.

Decomposition:
- Package clk_div_pkg holds DIV_W default, DEFAULT_DIV and the ceil-half helper function.
- Sub-module clk_div_chan contains one channel: counter, active/pending divisor, output registers. It is instantiated N_CH times via generate.
- The top level decodes div_load/div_sel into per-channel load strobes and fans out restart.

Test Plan:
- Reset release, DEFAULT_DIV=500, enable=all 1 -> clock_out high 250 cycles then low 250; tick pulses exactly every 500 cycles; first tick at cycle 500 after release.
- Load ch0 with 4 at cnt=100 -> pending[0]=1 until the 500-cycle wrap, then clock_out[0] pattern 1,1,0,0 repeating; ch1 unaffected.
- Load ch1=5, then ch1=7 before wrap -> only 7 applied (high 4, low 3); pending clears the cycle after the wrap.
- Channels at 6 and 9, assert restart at arbitrary phase -> both clock_out rise on the same cycle; ticks coincide every 18 cycles.
- Divisor 1 -> clock_out constant 1, tick constant 1. Divisor 0 -> both 0. Disable mid-high -> clock_out 0 next cycle; re-enable -> high for ceil(D/2) cycles.
- Assert reset mid-period with a pending load -> outputs 0 immediately; after release, period is 500 and pending=0.
